// File: rtl/bridge_arbiter.sv
// Two-master round-robin arbiter and access sequencer in front of Bridge.
// Each access is latched at grant, stretched by WAIT_CYC wait states and completed with a one-cycle ack.
module bridge_arbiter #(
   parameter int WAIT_CYC    = 1,
   parameter int DEV_ID_WD   = 2,
   parameter int DEV_ADDR_WD = 8,
   parameter int DEV_COUNT   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m0_wd,
   input  logic [31:0] m1_wd,
   output logic        m0_ack,
   output logic        m1_ack,
   output logic [31:0] m_rd,
   output logic        m_err,
   output logic [31:0] PrAddr,
   output logic [31:0] PrWD,
   output logic        PrWE,
   input  logic [31:0] PrRD,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [31:0] DEV_LIMIT     = 32'(DEV_COUNT);
   localparam logic [3:0]  WAIT_INIT     = 4'(WAIT_CYC);
   localparam logic        LAST_ON_GRANT = (WAIT_CYC == 0);

   state_t      state;
   logic        gnt;
   logic        last;
   logic [3:0]  cnt;
   logic        we;

   logic        pick;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wd;
   logic        bad;

   // An address is bad if its device ID is out of range or any bit above the ID field is set.
   function automatic logic addr_bad(input logic [31:0] a);
      logic [31:0] id;
      id = 32'(a[DEV_ADDR_WD+DEV_ID_WD-1:DEV_ADDR_WD]);
      return (id >= DEV_LIMIT) || (|a[31:DEV_ADDR_WD+DEV_ID_WD]);
   endfunction

   always_comb begin
      pick     = (m0_req && m1_req) ? ~last : m1_req;
      sel_we   = pick ? m1_we   : m0_we;
      sel_addr = pick ? m1_addr : m0_addr;
      sel_wd   = pick ? m1_wd   : m0_wd;
      bad      = addr_bad(PrAddr);
   end

   // The address/data outputs double as the transaction latches. The write strobe is
   // scheduled one edge ahead so that it lands exactly on the last BUSY cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         gnt    <= 1'b0;
         last   <= 1'b1;
         cnt    <= 4'd0;
         we     <= 1'b0;
         PrAddr <= '0;
         PrWD   <= '0;
         PrWE   <= 1'b0;
         m_rd   <= '0;
         m_err  <= 1'b0;
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         busy   <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         PrWE   <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  gnt    <= pick;
                  we     <= sel_we;
                  PrAddr <= sel_addr;
                  PrWD   <= sel_wd;
                  cnt    <= WAIT_INIT;
                  PrWE   <= sel_we & ~addr_bad(sel_addr) & LAST_ON_GRANT;
                  busy   <= 1'b1;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     PrWE <= we & ~bad;
                  end
               end else begin
                  m_rd   <= (we || bad) ? '0 : PrRD;
                  m_err  <= bad;
                  m0_ack <= ~gnt;
                  m1_ack <= gnt;
                  state  <= DONE;
               end
            end
            DONE: begin
               last  <= gnt;
               m_err <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: two instances (WAIT_CYC=1 and WAIT_CYC=0) share stimulus and are
// compared every cycle against a transaction-timeline model, plus directed literal checks.
module tb_bridge_arbiter;

   localparam int ADDR_WD = 8;
   localparam int DEV_CNT = 3;

   logic clk = 1'b0;
   logic reset;
   logic m0_req, m1_req, m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd, PrRD;

   logic [1:0]       m0_ack, m1_ack, m_err, PrWE, busy;
   logic [1:0][31:0] m_rd, PrAddr, PrWD;

   always #5 clk = ~clk;

   bridge_arbiter #(.WAIT_CYC(1), .DEV_ID_WD(2), .DEV_ADDR_WD(8), .DEV_COUNT(3)) dut0 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wd(m0_wd), .m1_wd(m1_wd),
      .m0_ack(m0_ack[0]), .m1_ack(m1_ack[0]), .m_rd(m_rd[0]), .m_err(m_err[0]),
      .PrAddr(PrAddr[0]), .PrWD(PrWD[0]), .PrWE(PrWE[0]), .PrRD(PrRD), .busy(busy[0])
   );

   bridge_arbiter #(.WAIT_CYC(0), .DEV_ID_WD(2), .DEV_ADDR_WD(8), .DEV_COUNT(3)) dut1 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wd(m0_wd), .m1_wd(m1_wd),
      .m0_ack(m0_ack[1]), .m1_ack(m1_ack[1]), .m_rd(m_rd[1]), .m_err(m_err[1]),
      .PrAddr(PrAddr[1]), .PrWD(PrWD[1]), .PrWE(PrWE[1]), .PrRD(PrRD), .busy(busy[1])
   );

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s inst=%0d t=%0t actual=%h required=%h", name, inst, $time, act, exp);
      end
   endtask

   function automatic int wc(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   // Model: each transaction is a start cycle s; busy for s+1..s+W+2, strobe at s+W+1, ack at s+W+2.
   int          cyc = 0;
   bit          model_on = 1'b0;
   bit          active [2];
   int          start  [2];
   bit          mgnt   [2];
   bit          mlast  [2];
   bit          mwe    [2];
   bit          mbad   [2];
   logic [31:0] maddr  [2];
   logic [31:0] mwd    [2];
   logic [31:0] exp_rd [2];
   bit          exp_err[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            active[i]  = 1'b0;
            mlast[i]   = 1'b1;
            maddr[i]   = '0;
            mwd[i]     = '0;
            exp_rd[i]  = '0;
            exp_err[i] = 1'b0;
         end else if (active[i] && cyc == start[i] + wc(i) + 1) begin
            exp_rd[i]  = (mwe[i] || mbad[i]) ? 32'h0 : PrRD;
            exp_err[i] = mbad[i];
         end else if (active[i] && cyc == start[i] + wc(i) + 2) begin
            active[i]  = 1'b0;
            mlast[i]   = mgnt[i];
            exp_err[i] = 1'b0;
         end else if (!active[i] && (m0_req || m1_req)) begin
            mgnt[i]   = (m0_req && m1_req) ? !mlast[i] : m1_req;
            mwe[i]    = mgnt[i] ? m1_we   : m0_we;
            maddr[i]  = mgnt[i] ? m1_addr : m0_addr;
            mwd[i]    = mgnt[i] ? m1_wd   : m0_wd;
            mbad[i]   = (maddr[i] >> ADDR_WD) >= DEV_CNT;
            start[i]  = cyc;
            active[i] = 1'b1;
         end
      end
      if (reset) model_on = 1'b1;
      cyc++;
   end

   bit e_busy[2], e_ack0[2], e_ack1[2], e_we[2];

   always @(negedge clk) begin
      if (model_on) begin
         for (int i = 0; i < 2; i++) begin
            e_busy[i] = active[i] && cyc > start[i];
            e_ack0[i] = active[i] && cyc == start[i] + wc(i) + 2 && !mgnt[i];
            e_ack1[i] = active[i] && cyc == start[i] + wc(i) + 2 && mgnt[i];
            e_we[i]   = active[i] && cyc == start[i] + wc(i) + 1 && mwe[i] && !mbad[i];
            checkOutput("busy",   i, 32'(busy[i]),   32'(e_busy[i]));
            checkOutput("m0_ack", i, 32'(m0_ack[i]), 32'(e_ack0[i]));
            checkOutput("m1_ack", i, 32'(m1_ack[i]), 32'(e_ack1[i]));
            checkOutput("PrWE",   i, 32'(PrWE[i]),   32'(e_we[i]));
            checkOutput("PrAddr", i, PrAddr[i], maddr[i]);
            checkOutput("PrWD",   i, PrWD[i],   mwd[i]);
            checkOutput("m_rd",   i, m_rd[i],   exp_rd[i]);
            checkOutput("m_err",  i, 32'(m_err[i]), 32'(exp_err[i]));
         end
      end
   end

   // One transaction from master m; returns latencies, strobe counts and instance-0 ack data.
   task automatic applyStimulus(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d,
                                output int lat0, output int lat1, output int we0, output int we1,
                                output logic [31:0] rd0, output logic err0);
      int n;
      n = cyc;
      if (m) begin m1_req = 1'b1; m1_we = w; m1_addr = a; m1_wd = d; end
      else   begin m0_req = 1'b1; m0_we = w; m0_addr = a; m0_wd = d; end
      lat0 = -1; lat1 = -1; we0 = 0; we1 = 0; rd0 = 'x; err0 = 1'bx;
      for (int k = 0; k < 20 && lat0 < 0; k++) begin
         @(negedge clk);
         we0 += int'(PrWE[0]);
         we1 += int'(PrWE[1]);
         if (lat1 < 0 && (m ? m1_ack[1] : m0_ack[1])) lat1 = cyc - n;
         if (m ? m1_ack[0] : m0_ack[0]) begin
            lat0 = cyc - n;
            rd0  = m_rd[0];
            err0 = m_err[0];
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int          l0, l1, w0, w1, nacks, cnt_we, cnt_ack;
   logic [31:0] r0;
   logic        e0;
   bit          order[4];

   initial begin
      reset = 1'b1;
      m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
      m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
      PrRD = 32'h1234_5678;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy",   0, 32'(busy[0]), 32'h0);
      checkOutput("rst_PrAddr", 0, PrAddr[0], 32'h0);
      checkOutput("rst_m_rd",   0, m_rd[0], 32'h0);
      checkOutput("rst_acks",   0, 32'({m0_ack[0], m1_ack[0]}), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Single read from M0 at device 1, offset 0x45
      applyStimulus(1'b0, 1'b0, 32'h0000_0145, 32'h0, l0, l1, w0, w1, r0, e0);
      checkOutput("read_lat",  0, 32'(l0), 32'd3);
      checkOutput("read_lat",  1, 32'(l1), 32'd2);
      checkOutput("read_rd",   0, r0, 32'h1234_5678);
      checkOutput("read_err",  0, 32'(e0), 32'h0);
      checkOutput("read_we",   0, 32'(w0), 32'h0);

      // Single write from M1 at device 2, offset 0x7e
      applyStimulus(1'b1, 1'b1, 32'h0000_027e, 32'hfedc_4321, l0, l1, w0, w1, r0, e0);
      checkOutput("write_lat", 0, 32'(l0), 32'd3);
      checkOutput("write_lat", 1, 32'(l1), 32'd2);
      checkOutput("write_we",  0, 32'(w0), 32'd1);
      checkOutput("write_we",  1, 32'(w1), 32'd1);
      checkOutput("write_rd",  0, r0, 32'h0);

      // Bad device ID, high-bit bad address, then a valid read
      applyStimulus(1'b0, 1'b0, 32'h0000_0310, 32'h0, l0, l1, w0, w1, r0, e0);
      checkOutput("bad_err",   0, 32'(e0), 32'h1);
      checkOutput("bad_rd",    0, r0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0001_0045, 32'h1111_2222, l0, l1, w0, w1, r0, e0);
      checkOutput("badhi_err", 0, 32'(e0), 32'h1);
      checkOutput("badhi_we",  0, 32'(w0), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0000_0001, 32'h0, l0, l1, w0, w1, r0, e0);
      checkOutput("good_err",  0, 32'(e0), 32'h0);
      checkOutput("good_rd",   0, r0, 32'h1234_5678);

      // Contention from reset: both requests held for four acks
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0120;
      nacks = 0;
      for (int k = 0; k < 60 && nacks < 4; k++) begin
         @(negedge clk);
         if (m0_ack[0] || m1_ack[0]) begin
            order[nacks] = m1_ack[0];
            nacks++;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      checkOutput("cont_count", 0, 32'(nacks), 32'd4);
      checkOutput("cont_order", 0, {28'h0, order[0], order[1], order[2], order[3]}, 32'b0101);
      repeat (6) @(negedge clk);

      // Reset during the first BUSY cycle of a write
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0204; m0_wd = 32'hcafe_0001;
      @(negedge clk);
      m0_req = 1'b0;
      cnt_we  = int'(PrWE[0]);
      checkOutput("abort_busy", 0, 32'(busy[0]), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_rst_busy", 0, 32'(busy[0]), 32'h0);
      checkOutput("abort_rst_addr", 0, PrAddr[0], 32'h0);
      checkOutput("abort_rst_wd",   0, PrWD[0], 32'h0);
      reset = 1'b0;
      cnt_ack = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cnt_we  += int'(PrWE[0]);
         cnt_ack += int'(m0_ack[0] | m1_ack[0]);
      end
      checkOutput("abort_we",  0, 32'(cnt_we), 32'h0);
      checkOutput("abort_ack", 0, 32'(cnt_ack), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0000_0033, 32'h0, l0, l1, w0, w1, r0, e0);
      checkOutput("after_abort_lat", 0, 32'(l0), 32'd3);

      // Randomized traffic with occasional reset, checked against the model
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         reset   = ($urandom_range(0, 99) == 0);
         m0_req  = ($urandom_range(0, 2) != 0);
         m1_req  = ($urandom_range(0, 2) != 0);
         m0_we   = $urandom_range(0, 1) != 0;
         m1_we   = $urandom_range(0, 1) != 0;
         m0_addr = 32'($urandom_range(0, 1023));
         m1_addr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 15) == 0) m0_addr |= 32'h400 << $urandom_range(0, 21);
         m0_wd   = $urandom;
         m1_wd   = $urandom;
         PrRD    = $urandom;
      end
      reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      repeat (8) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
